// File: rtl/montgomery_repeated_squarer.sv
// Repeated Montgomery squaring of a block-streamed operand.
// fsm_multiplier    : collects OP_BLOCKS blocks of n and m (LSB first), registers n*m.
// montgomery_reduce : takes a full product, streams in N and k blocks, performs REDC by
//                     2^R in BITS_IN_NUM-wide steps, then streams the residue out LSB first.
// montgomery_repeated_squarer (top)
//   clk_in, rst_in               : clock, async active-high reset
//   start_in, num_squarings_in   : start request and squaring count S (clamped)
//   operand_block_in/_valid_in   : Montgomery-form operand stream
//   N_in, k_in / consumed_*_out  : modulus and k streams feeding the reducer
//   result_block/valid/last_out  : result stream, pass_idx_out tags the producing pass
//   ready_out, done_out          : idle indicator, end-of-run pulse

module fsm_multiplier #(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned BITS_IN_NUM   = 2048
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       valid_in,
  input  logic [REGISTER_SIZE-1:0]   n_in,
  input  logic [REGISTER_SIZE-1:0]   m_in,
  output logic [2*BITS_IN_NUM-1:0]   product_out,
  output logic                       valid_out
);
  localparam int unsigned OP_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int unsigned BW = (OP_BLOCKS > 1) ? $clog2(OP_BLOCKS) : 1;
  localparam int unsigned PW = 2 * BITS_IN_NUM;
  localparam int unsigned HW = BITS_IN_NUM - REGISTER_SIZE;

  logic [HW-1:0]          n_q, m_q;
  logic [BITS_IN_NUM-1:0] n_full, m_full;
  logic [BW-1:0]          blk_q;
  logic [PW-1:0]          product_q;
  logic                   valid_q;

  // Current block completes the operand in the top position
  assign n_full = {n_in, n_q};
  assign m_full = {m_in, m_q};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      n_q       <= '0;
      m_q       <= '0;
      blk_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (valid_in) begin
        n_q <= n_full[BITS_IN_NUM-1:REGISTER_SIZE];
        m_q <= m_full[BITS_IN_NUM-1:REGISTER_SIZE];
        if (blk_q == BW'(OP_BLOCKS - 1)) begin
          blk_q     <= '0;
          product_q <= PW'(n_full) * PW'(m_full);
          valid_q   <= 1'b1;
        end else begin
          blk_q <= blk_q + BW'(1);
        end
      end
    end
  end

  assign product_out = product_q;
  assign valid_out   = valid_q;
endmodule

module montgomery_reduce #(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned BITS_IN_NUM   = 2048,
  parameter int unsigned R             = 4096
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       valid_in,
  input  logic [2*BITS_IN_NUM-1:0]   t_in,
  input  logic [REGISTER_SIZE-1:0]   N_in,
  input  logic [REGISTER_SIZE-1:0]   k_in,
  output logic                       consumed_N_out,
  output logic                       consumed_k_out,
  output logic [REGISTER_SIZE-1:0]   result_out,
  output logic                       valid_out
);
  localparam int unsigned W         = BITS_IN_NUM;
  localparam int unsigned OP_BLOCKS = W / REGISTER_SIZE;
  localparam int unsigned BW        = (OP_BLOCKS > 1) ? $clog2(OP_BLOCKS) : 1;
  localparam int unsigned UW        = 2 * W + 1;
  localparam int unsigned STEPS     = R / W;

  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_CALC, R_OUT} rstate_e;

  rstate_e          state_q;
  logic [BW-1:0]    cnt_q;
  logic [2*W-1:0]   t_q;
  logic [W-1:0]     n_q, k_q, res_q;
  logic [UW-1:0]    u_c;
  logic [W-1:0]     m_c;
  logic [W-1:0]     red_c;

  // REDC in W-bit digits; k = -N^-1 mod 2^W, so STEPS digits divide by 2^R
  always_comb begin
    u_c = UW'(t_q);
    m_c = '0;
    for (int unsigned s = 0; s < STEPS; s++) begin
      m_c = u_c[W-1:0] * k_q;
      u_c = (u_c + UW'(m_c) * UW'(n_q)) >> W;
    end
    if (u_c >= UW'(n_q)) u_c = u_c - UW'(n_q);
    red_c = u_c[W-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        R_IDLE: if (valid_in) begin
          t_q     <= t_in;
          cnt_q   <= '0;
          state_q <= R_LOAD;
        end
        R_LOAD: begin
          n_q <= {N_in, n_q[W-1:REGISTER_SIZE]};
          k_q <= {k_in, k_q[W-1:REGISTER_SIZE]};
          if (cnt_q == BW'(OP_BLOCKS - 1)) begin
            cnt_q   <= '0;
            state_q <= R_CALC;
          end else begin
            cnt_q <= cnt_q + BW'(1);
          end
        end
        R_CALC: begin
          res_q   <= red_c;
          state_q <= R_OUT;
        end
        R_OUT: begin
          res_q <= {REGISTER_SIZE'(0), res_q[W-1:REGISTER_SIZE]};
          if (cnt_q == BW'(OP_BLOCKS - 1)) begin
            cnt_q   <= '0;
            state_q <= R_IDLE;
          end else begin
            cnt_q <= cnt_q + BW'(1);
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign consumed_N_out = (state_q == R_LOAD);
  assign consumed_k_out = (state_q == R_LOAD);
  assign valid_out      = (state_q == R_OUT);
  assign result_out     = res_q[REGISTER_SIZE-1:0];
endmodule

module montgomery_repeated_squarer #(
  parameter int unsigned REGISTER_SIZE     = 32,
  parameter int unsigned BITS_IN_NUM       = 2048,
  parameter int unsigned R                 = 4096,
  parameter int unsigned MAX_SQUARINGS     = 16,
  parameter bit          EMIT_INTERMEDIATE = 1'b0,
  localparam int unsigned CW = $clog2(MAX_SQUARINGS + 1)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [CW-1:0]            num_squarings_in,
  input  logic [REGISTER_SIZE-1:0] operand_block_in,
  input  logic                     operand_valid_in,
  input  logic [REGISTER_SIZE-1:0] N_in,
  input  logic [REGISTER_SIZE-1:0] k_in,
  output logic                     consumed_N_out,
  output logic                     consumed_k_out,
  output logic [REGISTER_SIZE-1:0] result_block_out,
  output logic                     result_valid_out,
  output logic                     result_last_out,
  output logic [CW-1:0]            pass_idx_out,
  output logic                     ready_out,
  output logic                     done_out
);
  localparam int unsigned OP_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int unsigned BW = (OP_BLOCKS > 1) ? $clog2(OP_BLOCKS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SQUARE, FLUSH} state_e;

  state_e                   state_q;
  logic [CW-1:0]            s_q, pass_q;
  logic [BW-1:0]            blk_q, rblk_q;
  logic [CW-1:0]            s_clamp_c;
  logic                     load_fire_c, sq_fire_c, final_pass_c, echo_c, emit_c;
  logic                     mult_valid_c;
  logic [REGISTER_SIZE-1:0] mult_block_c;
  logic [2*BITS_IN_NUM-1:0] product;
  logic                     product_valid;
  logic [REGISTER_SIZE-1:0] red_block;
  logic                     red_valid;

  assign s_clamp_c = (num_squarings_in > CW'(MAX_SQUARINGS)) ? CW'(MAX_SQUARINGS)
                                                             : num_squarings_in;

  assign load_fire_c  = (state_q == LOAD) && operand_valid_in;
  assign sq_fire_c    = (state_q == SQUARE) && red_valid;
  assign final_pass_c = (pass_q == s_q);
  // S=0 bypasses the datapath entirely
  assign echo_c       = load_fire_c && (s_q == '0);
  assign emit_c       = echo_c || (sq_fire_c && (final_pass_c || EMIT_INTERMEDIATE));

  // Reducer output re-enters the multiplier in the same cycle until the last pass
  assign mult_valid_c = (load_fire_c && (s_q != '0)) || (sq_fire_c && !final_pass_c);
  assign mult_block_c = (state_q == LOAD) ? operand_block_in : red_block;

  fsm_multiplier #(
    .REGISTER_SIZE(REGISTER_SIZE),
    .BITS_IN_NUM  (BITS_IN_NUM)
  ) u_mult (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (mult_valid_c),
    .n_in       (mult_block_c),
    .m_in       (mult_block_c),
    .product_out(product),
    .valid_out  (product_valid)
  );

  montgomery_reduce #(
    .REGISTER_SIZE(REGISTER_SIZE),
    .BITS_IN_NUM  (BITS_IN_NUM),
    .R            (R)
  ) u_reduce (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (product_valid),
    .t_in          (product),
    .N_in          (N_in),
    .k_in          (k_in),
    .consumed_N_out(consumed_N_out),
    .consumed_k_out(consumed_k_out),
    .result_out    (red_block),
    .valid_out     (red_valid)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      s_q     <= '0;
      pass_q  <= '0;
      blk_q   <= '0;
      rblk_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_in) begin
          s_q     <= s_clamp_c;
          pass_q  <= '0;
          blk_q   <= '0;
          rblk_q  <= '0;
          state_q <= LOAD;
        end
        LOAD: if (operand_valid_in) begin
          if (blk_q == BW'(OP_BLOCKS - 1)) begin
            blk_q   <= '0;
            pass_q  <= CW'(1);
            state_q <= (s_q == '0) ? FLUSH : SQUARE;
          end else begin
            blk_q <= blk_q + BW'(1);
          end
        end
        SQUARE: if (red_valid) begin
          if (rblk_q == BW'(OP_BLOCKS - 1)) begin
            rblk_q <= '0;
            if (final_pass_c) begin
              pass_q  <= '0;
              state_q <= FLUSH;
            end else begin
              pass_q <= pass_q + CW'(1);
            end
          end else begin
            rblk_q <= rblk_q + BW'(1);
          end
        end
        FLUSH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_valid_out = emit_c;
  assign result_block_out = !emit_c ? '0 : (echo_c ? operand_block_in : red_block);
  assign result_last_out  = echo_c ? (blk_q == BW'(OP_BLOCKS - 1))
                                   : (sq_fire_c && final_pass_c && (rblk_q == BW'(OP_BLOCKS - 1)));
  assign pass_idx_out     = (emit_c && !echo_c) ? pass_q : '0;
  assign ready_out        = (state_q == IDLE);
  assign done_out         = (state_q == FLUSH);
endmodule

// File: tb/tb_montgomery_repeated_squarer.sv
// Directed bench: N = 2^63+1 so 2^63 = -1 (mod N) and Montgomery forms of powers of two are
// easy: Mont(2^e) = 2^e * 2^64 = -2^(e+1) = N - 2^(e+1). k = -N^-1 mod 2^64 = 2^63-1.
module tb_montgomery_repeated_squarer;
  localparam int unsigned RS = 32, BITS = 64, RR = 64, MAXS = 4, CW = 3;
  localparam int PASS_LAT = 6;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_valid = 1'b0;
  logic [CW-1:0] num = '0;
  logic [RS-1:0] op_blk = '0;
  logic [63:0] nmod = 64'h8000_0000_0000_0001;
  logic [63:0] kcon = 64'h7FFF_FFFF_FFFF_FFFF;

  logic [RS-1:0] n_a, k_a, n_b, k_b, rb_a, rb_b;
  logic cn_a, ck_a, cn_b, ck_b, rv_a, rv_b, rl_a, rl_b, rdy_a, rdy_b, dn_a, dn_b;
  logic [CW-1:0] pi_a, pi_b;

  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  montgomery_repeated_squarer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BITS), .R(RR),
    .MAX_SQUARINGS(MAXS), .EMIT_INTERMEDIATE(1'b1)) u_a (
    .clk_in(clk), .rst_in(rst), .start_in(start), .num_squarings_in(num),
    .operand_block_in(op_blk), .operand_valid_in(op_valid), .N_in(n_a), .k_in(k_a),
    .consumed_N_out(cn_a), .consumed_k_out(ck_a), .result_block_out(rb_a),
    .result_valid_out(rv_a), .result_last_out(rl_a), .pass_idx_out(pi_a),
    .ready_out(rdy_a), .done_out(dn_a));

  montgomery_repeated_squarer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BITS), .R(RR),
    .MAX_SQUARINGS(MAXS), .EMIT_INTERMEDIATE(1'b0)) u_b (
    .clk_in(clk), .rst_in(rst), .start_in(start), .num_squarings_in(num),
    .operand_block_in(op_blk), .operand_valid_in(op_valid), .N_in(n_b), .k_in(k_b),
    .consumed_N_out(cn_b), .consumed_k_out(ck_b), .result_block_out(rb_b),
    .result_valid_out(rv_b), .result_last_out(rl_b), .pass_idx_out(pi_b),
    .ready_out(rdy_b), .done_out(dn_b));

  // N and k block streams, advanced by each consume strobe
  logic ni_a, ki_a, ni_b, ki_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ni_a <= 1'b0; ki_a <= 1'b0; ni_b <= 1'b0; ki_b <= 1'b0;
    end else begin
      if (cn_a) ni_a <= ~ni_a;
      if (ck_a) ki_a <= ~ki_a;
      if (cn_b) ni_b <= ~ni_b;
      if (ck_b) ki_b <= ~ki_b;
    end
  end
  assign n_a = ni_a ? nmod[63:32] : nmod[31:0];
  assign k_a = ki_a ? kcon[63:32] : kcon[31:0];
  assign n_b = ni_b ? nmod[63:32] : nmod[31:0];
  assign k_b = ki_b ? kcon[63:32] : kcon[31:0];

  // Output monitor, sampled on the falling edge
  int cyc = 0, op_cyc = 0, last_cyc_a = -1, done_cyc_a = -1;
  int done_a_cnt = 0, done_b_cnt = 0, mfed = 0, strobes = 0;
  bit op_last = 1'b0;
  logic [31:0]   qd_a[$], qd_b[$];
  logic [CW-1:0] qp_a[$];
  bit            ql_a[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (op_valid && op_last) op_cyc = cyc;
    if (u_a.mult_valid_c) mfed = mfed + 1;
    if (rv_a || rv_b || dn_a || dn_b) strobes = strobes + 1;
    if (rv_a) begin
      qd_a.push_back(rb_a); qp_a.push_back(pi_a); ql_a.push_back(rl_a);
      if (rl_a) last_cyc_a = cyc;
    end
    if (rv_b) qd_b.push_back(rb_b);
    if (dn_a) begin done_a_cnt = done_a_cnt + 1; done_cyc_a = cyc; end
    if (dn_b) done_b_cnt = done_b_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    qd_a.delete(); qd_b.delete(); qp_a.delete(); ql_a.delete();
    last_cyc_a = -1; done_cyc_a = -1; done_a_cnt = 0; done_b_cnt = 0; mfed = 0;
  endtask

  function automatic logic [63:0] fin_a();
    int n = qd_a.size();
    return (n >= 2) ? {qd_a[n-1], qd_a[n-2]} : 64'hx;
  endfunction

  function automatic logic [63:0] fin_b();
    int n = qd_b.size();
    return (n >= 2) ? {qd_b[n-1], qd_b[n-2]} : 64'hx;
  endfunction

  // Reference: Montgomery form of 2^(2^p), i.e. base 2 squared p times
  function automatic logic [63:0] mont_sq2(input int p);
    return nmod - (64'd1 << ((1 << p) + 1));
  endfunction

  task automatic drive_operand(input logic [63:0] x);
    op_blk = x[31:0]; op_valid = 1'b1; tick();
    op_blk = x[63:32]; op_last = 1'b1; tick();
    op_valid = 1'b0; op_last = 1'b0; op_blk = '0;
  endtask

  task automatic run(input logic [CW-1:0] s, input logic [63:0] x, input bit stray, input bit midstart);
    clear();
    if (stray) begin
      op_blk = 32'hDEAD_BEEF; op_valid = 1'b1; tick(); tick(); op_valid = 1'b0;
    end
    start = 1'b1; num = s; tick(); start = 1'b0;
    drive_operand(x);
    if (midstart) begin
      tick(); tick(); start = 1'b1; num = 3'd1; tick(); start = 1'b0;
    end
    for (int i = 0; i < 300 && done_a_cnt == 0; i++) tick();
    chk("done_seen", 64'(done_a_cnt > 0), 64'd1);
    tick(); tick(); tick();
  endtask

  logic [63:0] x2;
  logic [23:0] pexp, pobs;
  logic [7:0]  lobs;

  initial begin
    x2 = nmod - 64'd4;  // Mont(2) = 2R mod N

    // Reset state
    #12;
    chk("rst_ready", 64'(rdy_a), 64'd1);
    chk("rst_valid", 64'(rv_a), 64'd0);
    chk("rst_last",  64'(rl_a), 64'd0);
    chk("rst_done",  64'(dn_a), 64'd0);
    chk("rst_block", 64'(rb_a), 64'd0);
    chk("rst_pass",  64'(pi_a), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // S=1: Mont(2) squared gives Mont(4)
    run(3'd1, x2, 1'b0, 1'b0);
    chk("s1_count",   64'(qd_a.size()), 64'd2);
    chk("s1_value",   fin_a(), 64'h7FFF_FFFF_FFFF_FFF9);
    chk("s1_lastpat", 64'({(qd_a.size() > 1) ? ql_a[1] : 1'b0, ql_a[0]}), 64'd2);
    chk("s1_pass",    64'(qp_a[0]), 64'd1);
    chk("s1_done_n",  64'(done_a_cnt), 64'd1);
    chk("s1_done_at", 64'(done_cyc_a - last_cyc_a), 64'd1);
    chk("s1_latency", 64'(last_cyc_a - op_cyc), 64'(PASS_LAT));
    chk("s1_fed",     64'(mfed), 64'd2);
    chk("s1_b_count", 64'(qd_b.size()), 64'd2);
    chk("s1_b_value", fin_b(), 64'h7FFF_FFFF_FFFF_FFF9);

    // S=0: combinational echo, multiplier untouched
    run(3'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    chk("s0_count",   64'(qd_a.size()), 64'd2);
    chk("s0_value",   fin_a(), 64'h1234_5678_9ABC_DEF0);
    chk("s0_pass",    64'(qp_a[0]), 64'd0);
    chk("s0_lastpat", 64'({(qd_a.size() > 1) ? ql_a[1] : 1'b0, ql_a[0]}), 64'd2);
    chk("s0_latency", 64'(last_cyc_a - op_cyc), 64'd0);
    chk("s0_done_at", 64'(done_cyc_a - last_cyc_a), 64'd1);
    chk("s0_fed",     64'(mfed), 64'd0);
    chk("s0_b_value", fin_b(), 64'h1234_5678_9ABC_DEF0);

    // S=4 with intermediates: Mont(2^2), Mont(2^4), Mont(2^8), Mont(2^16)
    run(3'd4, x2, 1'b0, 1'b0);
    chk("s4_count", 64'(qd_a.size()), 64'd8);
    pexp = '0; pobs = '0; lobs = '0;
    for (int i = 0; i < 8; i++) pexp[3*i +: 3] = 3'(i / 2 + 1);
    for (int i = 0; i < 8 && i < qd_a.size(); i++) begin
      pobs[3*i +: 3] = qp_a[i];
      lobs[i] = ql_a[i];
    end
    chk("s4_passpat", 64'(pobs), 64'(pexp));
    chk("s4_lastpat", 64'(lobs), 64'h80);
    for (int p = 1; p <= 4; p++)
      if (qd_a.size() >= 2 * p)
        chk($sformatf("s4_pass%0d", p), {qd_a[2*p-1], qd_a[2*p-2]}, mont_sq2(p));
    chk("s4_latency", 64'(last_cyc_a - op_cyc), 64'(4 * PASS_LAT));
    chk("s4_fed",     64'(mfed), 64'd8);
    chk("s4_b_count", 64'(qd_b.size()), 64'd2);
    chk("s4_b_value", fin_b(), mont_sq2(4));
    chk("s4_done_n",  64'(done_a_cnt), 64'd1);

    // Count above MAX_SQUARINGS clamps to 4
    run(3'd7, x2, 1'b0, 1'b0);
    chk("clamp_b_value", fin_b(), mont_sq2(4));
    chk("clamp_count",   64'(qd_a.size()), 64'd8);
    chk("clamp_lastpass", 64'((qp_a.size() > 0) ? qp_a[qp_a.size()-1] : 3'd0), 64'd4);

    // Reset during pass 2 of S=3
    clear();
    start = 1'b1; num = 3'd3; tick(); start = 1'b0;
    drive_operand(x2);
    for (int i = 0; i < 100 && qd_a.size() < 2; i++) tick();
    chk("mid_pass1_seen", 64'(qd_a.size()), 64'd2);
    tick(); tick();
    rst = 1'b1; #1;
    chk("mid_rst_valid", 64'(rv_a | rv_b), 64'd0);
    chk("mid_rst_ready", 64'(rdy_a & rdy_b), 64'd1);
    chk("mid_rst_done",  64'(dn_a | dn_b), 64'd0);
    chk("mid_rst_block", 64'(rb_a), 64'd0);
    chk("mid_rst_pass",  64'(pi_a), 64'd0);
    strobes = 0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("mid_no_strobes", 64'(strobes), 64'd0);
    run(3'd2, x2, 1'b0, 1'b0);
    chk("after_rst_value",   fin_a(), mont_sq2(2));
    chk("after_rst_b_value", fin_b(), mont_sq2(2));
    chk("after_rst_count",   64'(qd_a.size()), 64'd4);

    // Stray operand strobes in IDLE and a start during SQUARE change nothing
    run(3'd2, x2, 1'b1, 1'b1);
    chk("noise_value",   fin_a(), mont_sq2(2));
    chk("noise_b_value", fin_b(), mont_sq2(2));
    chk("noise_count",   64'(qd_a.size()), 64'd4);
    chk("noise_done_n",  64'(done_a_cnt), 64'd1);
    chk("noise_ready",   64'(rdy_a), 64'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
